mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control unit: the issuing end of the ALU operation interface.
//  Decodes opcode/funct and drives alu_op with the team's ALU codes.
//  Samples the ALU ZERO flag for branches.
//  Sequences datapath enables and mux selects, and waits on the memory ready handshake.
// PARAMETERS
//  (none) - state encoding and opcode/funct values are fixed by the MIPS ISA subset below
// PORTS
//  clk            in   1   system clock; all state changes on posedge
//  rst            in   1   asynchronous, active-high reset
//  opcode         in   6   IR[31:26], stable from DECODE onward
//  funct          in   6   IR[5:0]
//  alu_zero       in   1   ALU ZERO flag; sampled only in BRANCH
//  mem_ready      in   1   memory done; completes the current mem_read/mem_write
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load if alu_zero
//  iord           out  1   0 = address from PC, 1 = address from ALUOut
//  mem_read       out  1   memory read request, held until mem_ready
//  mem_write      out  1   memory write request, held until mem_ready
//  ir_write       out  1   IR load
//  mem_to_reg     out  1   register write data: 0 = ALUOut, 1 = MDR
//  reg_dst        out  1   destination register: 0 = rt, 1 = rd
//  reg_write      out  1   register file write enable
//  alu_src_a      out  1   ALU A input: 0 = PC, 1 = A reg
//  alu_src_b      out  2   ALU B input: 00 = B, 01 = const 4, 10 = signext, 11 = signext<<2
//  pc_source      out  2   PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//  alu_op         out  4   AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, SLT 0111, NOR 1100
//  illegal_instr  out  1   1-cycle pulse on unsupported opcode/funct
//  state_out      out  4   current state, for debug/verification
// BEHAVIOUR
//  - States (state_out code):
//    FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI 10, IWB 11.
//  - Outputs are Moore decodes of state, except where noted; outputs not listed below for a state are 0.
//  - Reset (async): state = FETCH; while rst = 1, all outputs are forced to 0.
//    The first FETCH request appears in the first cycle after rst deasserts.
//  - FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
//    - ir_write and pc_write equal mem_ready; pc_source = 00.
//    - Stay in FETCH until mem_ready, then go to DECODE.
//  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = ADD (branch target into ALUOut). Next state by opcode:
//    0x00 -> EXEC, 0x23/0x2B -> MEMADR, 0x04 -> BRANCH, 0x02 -> JUMP, 0x08 -> ADDI.
//    Any other opcode: illegal_instr = 1 and next state FETCH.
//  - EXEC: alu_src_a = 1, alu_src_b = 00; alu_op from funct:
//    20 -> ADD, 22 -> SUB, 24 -> AND, 25 -> OR, 27 -> NOR, 2A -> SLT, 00 -> SLL.
//    Unknown funct: alu_op = ADD, illegal_instr = 1, next state FETCH (no RWB).
//  - RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next FETCH.
//  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Next MEMRD for 0x23, MEMWR for 0x2B.
//  - MEMRD: mem_read = 1, iord = 1. Hold until mem_ready, then MEMWB.
//  - MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next FETCH.
//  - MEMWR: mem_write = 1, iord = 1. Hold until mem_ready, then FETCH.
//  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_write_cond = 1, pc_source = 01.
//    PC loads iff alu_zero in this cycle. Next FETCH.
//  - JUMP: pc_write = 1, pc_source = 10. Next FETCH.
//  - ADDI: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Next IWB.
//  - IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next FETCH.
//  - Instruction latency with mem_ready = 1 on first request (cycles, including FETCH):
//    R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each extra wait cycle adds 1.
//  - mem_read and mem_write are never both 1; a request stays stable while mem_ready = 0.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - alu_zero outside BRANCH is ignored.
//  - Reset mid-instruction: immediate return to FETCH, no partial writes after rst rises.
//  - Unused state codes 12-15 go to FETCH next cycle with all outputs 0.
// TESTING
//  1. rst pulse mid-MEMWR -> state_out = 0 and mem_write = 0 immediately (async). After release: mem_read = 1, iord = 0.
//  2. add (op 00, funct 20), mem_ready = 1 -> states 0, 1, 6, 7; alu_op = 0010 in EXEC.
//     reg_write = 1 and reg_dst = 1 only in RWB.
//  3. lw (op 23), mem_ready low 2 cycles in MEMRD -> states 0, 1, 2, 3, 3, 3, 4; mem_to_reg = 1 in MEMWB.
//  4. beq (op 04) with alu_zero = 1, then with alu_zero = 0 -> pc_write_cond = 1 and alu_op = 0110 in BRANCH both times.
//     Bench PC model loads only in the zero = 1 case.
//  5. Each funct 00/22/24/25/27/2A -> alu_op 0011/0110/0000/0001/1100/0111.
//     funct 3F -> illegal_instr pulse and no reg_write.
//  6. opcode 3F -> illegal_instr = 1 in DECODE, next state FETCH. j (op 02) -> pc_write = 1, pc_source = 10.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Multicycle MIPS control unit. It sequences the datapath enables
//            and mux selects, decodes opcode/funct into ALU operation codes,
//            samples the ALU zero flag for branches, and waits on the memory
//            ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_op,
  output logic       illegal_instr,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDI   = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_sll = 4'b0011;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_slt = 4'b0111;
  localparam logic [3:0] c_alu_nor = 4'b1100;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  state_t state_q;
  state_t state_d;

  // State register; reset returns to FETCH immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Outputs are combinational from the state
  // so that the first FETCH request is visible as soon as rst falls, and are
  // gated to zero for as long as rst is high.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = c_alu_and;
    illegal_instr = 1'b0;
    state_out     = state_q;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle; IR and PC only load on completion.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = c_alu_add;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = c_alu_add;
        case (opcode)
          c_op_rtype: state_d = S_EXEC;
          c_op_lw,
          c_op_sw:    state_d = S_MEMADR;
          c_op_beq:   state_d = S_BRANCH;
          c_op_j:     state_d = S_JUMP;
          c_op_addi:  state_d = S_ADDI;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = c_alu_add;
        state_d   = (opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_RWB;
        case (funct)
          6'h20:   alu_op = c_alu_add;
          6'h22:   alu_op = c_alu_sub;
          6'h24:   alu_op = c_alu_and;
          6'h25:   alu_op = c_alu_or;
          6'h27:   alu_op = c_alu_nor;
          6'h2A:   alu_op = c_alu_slt;
          6'h00:   alu_op = c_alu_sll;
          default: begin
            // Unsupported funct: abandon the instruction before writeback.
            alu_op        = c_alu_add;
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // A - B; the datapath qualifies the PC load with alu_zero.
        alu_src_a     = 1'b1;
        alu_op        = c_alu_sub;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = c_alu_add;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        // Unused encodings: all outputs stay at their zero defaults.
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 4'b0000;
      illegal_instr = 1'b0;
      state_out     = 4'd0;
    end
  end

endmodule
`default_nettype wire
